vector_register_file: RTL and testbench

VECTOR_REGISTER_FILE -- requirements
Module: vector_register_file

---
 rtl/vector_register_file.sv | 83 ++++++++
 tb/tb_vector_register_file.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector_register_file.sv
// Multi-lane vector register file: two combinational read ports, one lane-masked write port,
// optional same-cycle write forwarding, optional hardwired zero register and a write counter.
module vector_register_file #(
    parameter int LANE_W   = 8,
    parameter int LANES    = 16,
    parameter int DEPTH    = 16,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [LANES-1:0]           wmask,
    input  logic [LANES*LANE_W-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr_a,
    input  logic [$clog2(DEPTH)-1:0]   raddr_b,
    output logic [LANES*LANE_W-1:0]    rdata_a,
    output logic [LANES*LANE_W-1:0]    rdata_b,
    output logic [15:0]                wr_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = LANES * LANE_W;

    logic [VW-1:0] regFile [DEPTH];
    logic [VW-1:0] bitMask;
    logic [15:0]   wrCount;
    logic          zeroTarget;
    logic          commit;

    // Expand the per-lane mask to a per-bit mask so merging is a plain and/or.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_mask
            assign bitMask[gi*LANE_W +: LANE_W] = {LANE_W{wmask[gi]}};
        end
    endgenerate

    assign zeroTarget = (ZERO_REG != 0) && (waddr == '0);
    // A commit is a write that actually changes storage and counts; also gates forwarding.
    assign commit = we && (|wmask) && !zeroTarget && !rst && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= '0;
            end
        end else if (commit) begin
            regFile[waddr] <= (regFile[waddr] & ~bitMask) | (wdata & bitMask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wrCount <= '0;
        end else if (commit && (wrCount != 16'hFFFF)) begin
            wrCount <= wrCount + 16'd1;
        end
    end

    assign wr_count = wrCount;

    function automatic logic [VW-1:0] readPort(input logic [AW-1:0] addr);
        logic [VW-1:0] stored;
        stored = regFile[addr];
        // Register 0 reads zero even before the first reset when hardwired.
        if ((ZERO_REG != 0) && (addr == '0)) begin
            stored = '0;
        end
        if ((BYPASS != 0) && commit && (addr == waddr)) begin
            readPort = (stored & ~bitMask) | (wdata & bitMask);
        end else begin
            readPort = stored;
        end
    endfunction

    always_comb begin
        rdata_a = readPort(raddr_a);
        rdata_b = readPort(raddr_b);
    end

endmodule

// File: tb/tb_vector_register_file.sv
// Directed bench for vector_register_file: default, no-bypass and zero-register variants share
// one stimulus stream; each check is an immediate assertion against hand-computed values.
module tb_vector_register_file;
    logic         clk = 1'b0;
    logic         rst, clr, we;
    logic [3:0]   waddr, raddr_a, raddr_b;
    logic [15:0]  wmask;
    logic [127:0] wdata;

    logic [127:0] dA, dB, nA, nB, zA, zB;
    logic [15:0]  dCnt, nCnt, zCnt;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V1    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] V2    = 128'h00112233_44556677_8899AABB_AAAAAAAA;
    localparam logic [127:0] V3    = 128'h00112233_44556677_55555555_AAAAAAAA;
    localparam logic [127:0] ALL11 = {16{8'h11}};
    localparam logic [127:0] ALLAA = {16{8'hAA}};
    localparam logic [127:0] ALL55 = {16{8'h55}};
    localparam logic [127:0] ALLFF = {16{8'hFF}};
    localparam logic [127:0] ALL77 = {16{8'h77}};
    localparam logic [127:0] ALL99 = {16{8'h99}};
    localparam logic [127:0] ALLC3 = {16{8'hC3}};
    localparam logic [127:0] LANE0C3 = 128'h0000_0000_0000_0000_0000_0000_0000_00C3;

    always #5 clk = ~clk;

    vector_register_file dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(dA), .rdata_b(dB), .wr_count(dCnt)
    );

    vector_register_file #(.BYPASS(0)) dutNb (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nA), .rdata_b(nB), .wr_count(nCnt)
    );

    vector_register_file #(.ZERO_REG(1)) dutZ (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(zA), .rdata_b(zB), .wr_count(zCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkCounts(input string tag, input logic [15:0] d, input logic [15:0] n,
                               input logic [15:0] z);
        check({tag, "_cnt"},   {112'd0, dCnt}, {112'd0, d});
        check({tag, "_cntNb"}, {112'd0, nCnt}, {112'd0, n});
        check({tag, "_cntZ"},  {112'd0, zCnt}, {112'd0, z});
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] m, input logic [127:0] d);
        we = 1'b1; waddr = a; wmask = m; wdata = d;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b1; waddr = 4'd1; wmask = 16'hFFFF; wdata = ALL99;
        raddr_a = '0; raddr_b = '0;
        tick();
        rst = 1'b0; we = 1'b0;

        // Reset state: every register reads zero on both ports, counters zero.
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(15 - i);
            #1;
            check($sformatf("rst_a%0d", i), dA, '0);
            check($sformatf("rst_b%0d", i), dB, '0);
        end
        checkCounts("rst", 16'd0, 16'd0, 16'd0);

        // Full write then partial low-lane write to reg 3.
        write(4'd3, 16'hFFFF, V1); tick();
        write(4'd3, 16'h000F, ALLAA); tick();
        we = 1'b0; raddr_a = 4'd3; raddr_b = 4'd3; #1;
        check("mask_a", dA, V2);
        check("mask_b", dB, V2);
        check("mask_nb", nA, V2);
        checkCounts("mask", 16'd2, 16'd2, 16'd2);

        // All-zero mask: no storage change, no count.
        write(4'd3, 16'h0000, '0); tick();
        we = 1'b0; #1;
        check("zmask_a", dA, V2);
        checkCounts("zmask", 16'd2, 16'd2, 16'd2);

        // Same-cycle forwarding vs. next-cycle visibility.
        raddr_a = 4'd5;
        write(4'd5, 16'hFFFF, ALL11); #1;
        check("byp_a", dA, ALL11);
        check("nobyp_a", nA, '0);
        tick();
        we = 1'b0; #1;
        check("nobyp_next", nA, ALL11);
        checkCounts("byp", 16'd3, 16'd3, 16'd3);

        // Partial forward: masked lanes from wdata, the rest from storage.
        raddr_b = 4'd3;
        write(4'd3, 16'h00F0, ALL55); #1;
        check("pbyp_b", dB, V3);
        check("pnobyp_b", nB, V2);
        tick();
        we = 1'b0; #1;
        check("pnobyp_next", nB, V3);

        // Register 0 hardwired to zero in the ZERO_REG variant.
        raddr_a = 4'd0;
        write(4'd0, 16'hFFFF, ALLFF); #1;
        check("zr_nofwd", zA, '0);
        check("zr_fwd_default", dA, ALLFF);
        tick();
        we = 1'b0; #1;
        check("zr_read", zA, '0);
        check("zr_default_read", dA, ALLFF);
        checkCounts("zr", 16'd5, 16'd5, 16'd4);

        // Clear beats a simultaneous write; forwarding suppressed during clear.
        raddr_a = 4'd2; raddr_b = 4'd5;
        clr = 1'b1;
        write(4'd2, 16'hFFFF, ALL77); #1;
        check("clr_nofwd_a", dA, '0);
        check("clr_stored_b", dB, ALL11);
        tick();
        clr = 1'b0; we = 1'b0; #1;
        check("clr_reg2", dA, '0);
        check("clr_reg5", dB, '0);
        raddr_a = 4'd3; #1;
        check("clr_reg3", dA, '0);
        checkCounts("clr", 16'd0, 16'd0, 16'd0);

        // Saturation of the write counter.
        write(4'd7, 16'h0001, ALLC3);
        for (int i = 0; i < 65534; i++) tick();
        checkCounts("sat_fffe", 16'hFFFE, 16'hFFFE, 16'hFFFE);
        tick();
        checkCounts("sat_ffff", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        tick();
        checkCounts("sat_hold", 16'hFFFF, 16'hFFFF, 16'hFFFF);
        we = 1'b0; raddr_a = 4'd7; #1;
        check("sat_reg7", dA, LANE0C3);

        // Reset with a write pending: write discarded, forwarding suppressed.
        rst = 1'b1;
        write(4'd7, 16'hFFFF, ALL99); #1;
        check("rst_nofwd", dA, LANE0C3);
        tick();
        rst = 1'b0; we = 1'b0; #1;
        check("rst_reg7", dA, '0);
        checkCounts("rst2", 16'd0, 16'd0, 16'd0);

        // Normal operation resumes on the first edge after reset.
        raddr_a = 4'd8;
        write(4'd8, 16'hFFFF, ALL11); tick();
        we = 1'b0; #1;
        check("post_rst_wr", dA, ALL11);
        checkCounts("post_rst", 16'd1, 16'd1, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
